// File: rtl/prediction_stat_tracker_pkg.sv
// Shared trend-history encodings and helpers for the per-predictor confidence trackers.
// The TREND_* macros are also used directly by the arbiter bench.
`ifndef TREND_STRONG_MISS
`define TREND_STRONG_MISS 2'b00
`define TREND_RECOVERING  2'b01
`define TREND_SLIPPING    2'b10
`define TREND_STRONG_HIT  2'b11
`define TREND_RESET       `TREND_RECOVERING
`endif

package prediction_stat_tracker_pkg;

    typedef enum logic [1:0] {
        TREND_STRONG_MISS = `TREND_STRONG_MISS,
        TREND_RECOVERING  = `TREND_RECOVERING,
        TREND_SLIPPING    = `TREND_SLIPPING,
        TREND_STRONG_HIT  = `TREND_STRONG_HIT
    } trend_e;

    localparam trend_e TREND_RESET_STATE = TREND_RECOVERING;

    // The arbiter consumes the history as a one-hot vector.
    function automatic logic [3:0] trend_onehot(input trend_e hist);
        return 4'b0001 << hist;
    endfunction

endpackage

// File: rtl/prediction_stat_tracker_sat_updown_counter.sv
// Saturating up/down counter: +1 or -DEC_STEP with floor at 0 and ceiling at 2^WIDTH-1,
// plus synchronous clear and an external load path.
module sat_updown_counter #(
    parameter int WIDTH    = 5,
    parameter int DEC_STEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step_en,
    input  logic             step_up,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] step_value
);

    localparam logic [WIDTH:0]   DEC_EXT   = DEC_STEP[WIDTH:0];
    localparam logic [WIDTH:0]   ONE_EXT   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] COUNT_MIN = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH:0]   inc_ext_s;
    logic [WIDTH:0]   dec_ext_s;
    logic [WIDTH-1:0] step_value_s;

    assign inc_ext_s = {1'b0, count_r} + ONE_EXT;
    assign dec_ext_s = {1'b0, count_r} - DEC_EXT;

    // Stepped value computed one bit wider so carry/borrow selects the saturation bound.
    always_comb begin
        step_value_s = count_r;
        if (step_up) begin
            if (inc_ext_s[WIDTH]) begin
                step_value_s = COUNT_MAX;
            end else begin
                step_value_s = inc_ext_s[WIDTH-1:0];
            end
        end else begin
            if (dec_ext_s[WIDTH]) begin
                step_value_s = COUNT_MIN;
            end else begin
                step_value_s = dec_ext_s[WIDTH-1:0];
            end
        end
    end

    // Count register: clear beats load, load beats a plain step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= COUNT_MIN;
        end else if (clear) begin
            count_r <= COUNT_MIN;
        end else if (load_en) begin
            count_r <= load_value;
        end else if (step_en) begin
            count_r <= step_value_s;
        end else begin
            count_r <= count_r;
        end
    end

    assign count      = count_r;
    assign step_value = step_value_s;

endmodule

// File: rtl/prediction_stat_tracker.sv
// Per-predictor confidence tracker: saturating confidence count, 2-outcome trend history
// and periodic aging (halving) of the count, all registered for the prediction arbiter.
module prediction_stat_tracker
    import prediction_stat_tracker_pkg::*;
#(
    parameter int STAT_COUNTER_WIDTH   = 5,
    parameter int MISS_PENALTY         = 2,
    parameter int DECAY_INTERVAL_WIDTH = 6,
    parameter int DECAY_ENABLE         = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          update_valid,
    input  logic                          update_correct,
    output logic [STAT_COUNTER_WIDTH-1:0] stat_count,
    output logic [3:0]                    trend_decode,
    output logic                          decay_pulse
);

    localparam int W = STAT_COUNTER_WIDTH;
    localparam int D = DECAY_INTERVAL_WIDTH;

    logic         accept_s;
    logic         wrap_s;
    logic [W-1:0] step_value_s;
    logic [W-1:0] halved_s;
    trend_e       hist_r;
    trend_e       hist_next_s;
    logic [3:0]   trend_decode_r;
    logic         decay_pulse_r;

    assign accept_s = update_valid & ~clear;
    assign halved_s = {1'b0, step_value_s[W-1:1]};

    sat_updown_counter #(
        .WIDTH    (W),
        .DEC_STEP (MISS_PENALTY)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .step_en    (accept_s),
        .step_up    (update_correct),
        .load_en    (wrap_s),
        .load_value (halved_s),
        .count      (stat_count),
        .step_value (step_value_s)
    );

    // Trend FSM next state: shift in the latest outcome; clear returns to the reset trend.
    always_comb begin
        hist_next_s = hist_r;
        if (clear) begin
            hist_next_s = TREND_RESET_STATE;
        end else if (update_valid) begin
            hist_next_s = trend_e'({hist_r[0], update_correct});
        end else begin
            hist_next_s = hist_r;
        end
    end

    // Trend FSM state and its registered one-hot decode move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r         <= TREND_RESET_STATE;
            trend_decode_r <= 4'b0010;
        end else begin
            hist_r         <= hist_next_s;
            trend_decode_r <= trend_onehot(hist_next_s);
        end
    end

    generate
        if (DECAY_ENABLE != 0) begin : g_decay
            localparam logic [D-1:0] INTERVAL_ONE  = {{(D-1){1'b0}}, 1'b1};
            localparam logic [D-1:0] INTERVAL_LAST = {D{1'b1}};
            logic [D-1:0] interval_r;

            assign wrap_s = accept_s && (interval_r == INTERVAL_LAST);

            // Aging interval counts accepted updates only and wraps naturally.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    interval_r <= {D{1'b0}};
                end else if (clear) begin
                    interval_r <= {D{1'b0}};
                end else if (update_valid) begin
                    interval_r <= interval_r + INTERVAL_ONE;
                end else begin
                    interval_r <= interval_r;
                end
            end
        end else begin : g_no_decay
            assign wrap_s = 1'b0;
        end
    endgenerate

    // One-cycle pulse following each aging event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decay_pulse_r <= 1'b0;
        end else begin
            decay_pulse_r <= wrap_s;
        end
    end

    assign trend_decode = trend_decode_r;
    assign decay_pulse  = decay_pulse_r;

endmodule

// File: tb/tb_prediction_stat_tracker.sv
// Directed bench: instance A uses default parameters, instance B uses a 4-update aging interval.
module tb_prediction_stat_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_a, valid_a, correct_a;
    logic       clear_b, valid_b, correct_b;
    logic [4:0] stat_a, stat_b;
    logic [3:0] trend_a, trend_b;
    logic       pulse_a, pulse_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prediction_stat_tracker u_dut_a (
        .clk(clk), .rst(rst), .clear(clear_a), .update_valid(valid_a),
        .update_correct(correct_a), .stat_count(stat_a), .trend_decode(trend_a),
        .decay_pulse(pulse_a)
    );

    prediction_stat_tracker #(.DECAY_INTERVAL_WIDTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .clear(clear_b), .update_valid(valid_b),
        .update_correct(correct_b), .stat_count(stat_b), .trend_decode(trend_b),
        .decay_pulse(pulse_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [4:0] s, input logic [3:0] t, input logic p);
        check_eq({tag, ".stat"}, 32'(stat_a), 32'(s));
        check_eq({tag, ".trend"}, 32'(trend_a), 32'(t));
        check_eq({tag, ".pulse"}, 32'(pulse_a), 32'(p));
    endtask

    task automatic chk_b(input string tag, input logic [4:0] s, input logic [3:0] t, input logic p);
        check_eq({tag, ".stat"}, 32'(stat_b), 32'(s));
        check_eq({tag, ".trend"}, 32'(trend_b), 32'(t));
        check_eq({tag, ".pulse"}, 32'(pulse_b), 32'(p));
    endtask

    task automatic upd_a(input logic c);
        valid_a = 1'b1; correct_a = c;
        @(posedge clk); #1;
        valid_a = 1'b0; correct_a = 1'b0;
    endtask

    task automatic upd_b(input logic c);
        valid_b = 1'b1; correct_b = c;
        @(posedge clk); #1;
        valid_b = 1'b0; correct_b = 1'b0;
    endtask

    task automatic clear_only_a();
        clear_a = 1'b1;
        @(posedge clk); #1;
        clear_a = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_a = 1'b0; valid_a = 1'b0; correct_a = 1'b0;
        clear_b = 1'b0; valid_b = 1'b0; correct_b = 1'b0;
        #1;
        chk_a("rst_async_a", 5'd0, 4'b0010, 1'b0);
        idle(2);
        chk_a("rst_a", 5'd0, 4'b0010, 1'b0);
        chk_b("rst_b", 5'd0, 4'b0010, 1'b0);
        rst = 1'b0;
        idle(1);

        // 40 correct updates: count climbs then saturates at 31, trend strong hit after first.
        for (int i = 1; i <= 40; i++) begin
            upd_a(1'b1);
            chk_a($sformatf("t1_u%0d", i), (i > 31) ? 5'd31 : 5'(i), 4'b1000, 1'b0);
        end

        // From count 1 with history 11, one miss floors at 0 rather than wrapping.
        clear_only_a();
        chk_a("t2_clear", 5'd0, 4'b0010, 1'b0);
        upd_a(1'b1);
        chk_a("t2_hit", 5'd1, 4'b1000, 1'b0);
        upd_a(1'b0);
        chk_a("t2_miss", 5'd0, 4'b0100, 1'b0);

        // Idle gap holds state; second miss reaches strong-miss trend.
        idle(3);
        chk_a("t3_gap", 5'd0, 4'b0100, 1'b0);
        correct_a = 1'b1;
        idle(1);
        correct_a = 1'b0;
        chk_a("t3_ignored", 5'd0, 4'b0100, 1'b0);
        upd_a(1'b0);
        chk_a("t3_miss2", 5'd0, 4'b0001, 1'b0);
        upd_a(1'b1);
        chk_a("t3_rec1", 5'd1, 4'b0010, 1'b0);
        upd_a(1'b1);
        chk_a("t3_rec2", 5'd2, 4'b1000, 1'b0);
        upd_a(1'b1);
        chk_a("t3_rec3", 5'd3, 4'b1000, 1'b0);
        upd_a(1'b0);
        chk_a("t3_sub", 5'd1, 4'b0100, 1'b0);

        // Aging every 4 accepted updates on instance B.
        upd_b(1'b1); chk_b("t4_u1", 5'd1, 4'b1000, 1'b0);
        upd_b(1'b1); chk_b("t4_u2", 5'd2, 4'b1000, 1'b0);
        upd_b(1'b1); chk_b("t4_u3", 5'd3, 4'b1000, 1'b0);
        upd_b(1'b1); chk_b("t4_u4", 5'd2, 4'b1000, 1'b1);
        idle(1);     chk_b("t4_gap", 5'd2, 4'b1000, 1'b0);
        upd_b(1'b1); chk_b("t4_u5", 5'd3, 4'b1000, 1'b0);
        upd_b(1'b1); chk_b("t4_u6", 5'd4, 4'b1000, 1'b0);
        upd_b(1'b1); chk_b("t4_u7", 5'd5, 4'b1000, 1'b0);
        upd_b(1'b1); chk_b("t4_u8", 5'd3, 4'b1000, 1'b1);
        upd_b(1'b1); chk_b("t4_u9", 5'd4, 4'b1000, 1'b0);
        upd_b(1'b1); chk_b("t4_u10", 5'd5, 4'b1000, 1'b0);
        upd_b(1'b1); chk_b("t4_u11", 5'd6, 4'b1000, 1'b0);
        upd_b(1'b0); chk_b("t4_u12", 5'd2, 4'b0100, 1'b1);

        // Clear together with an update: clear wins and the aging interval restarts.
        clear_only_a();
        for (int i = 0; i < 20; i++) upd_a(1'b1);
        chk_a("t5_pre", 5'd20, 4'b1000, 1'b0);
        clear_a = 1'b1; valid_a = 1'b1; correct_a = 1'b1;
        @(posedge clk); #1;
        clear_a = 1'b0; valid_a = 1'b0; correct_a = 1'b0;
        chk_a("t5_clr_upd", 5'd0, 4'b0010, 1'b0);
        for (int i = 0; i < 63; i++) upd_a(1'b1);
        chk_a("t5_u63", 5'd31, 4'b1000, 1'b0);
        upd_a(1'b1);
        chk_a("t5_u64", 5'd15, 4'b1000, 1'b1);
        idle(1);
        chk_a("t5_after", 5'd15, 4'b1000, 1'b0);

        // Asynchronous reset in the middle of an update burst.
        valid_a = 1'b1; correct_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("t6_burst.stat", 32'(stat_a), 32'd17);
        #2 rst = 1'b1;
        #1;
        chk_a("t6_async", 5'd0, 4'b0010, 1'b0);
        valid_a = 1'b0; correct_a = 1'b0;
        idle(1);
        rst = 1'b0;
        upd_a(1'b1);
        chk_a("t6_post", 5'd1, 4'b1000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
